uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered 8N1 UART transmitter, the return path of the host serial link whose receive side feeds column/row/character commands into the text-mode VGA controller. Accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first on `tx_o` at 115200 baud from the 25 MHz pixel clock. Lets the controller echo received commands, report status, or read back characters from the text buffer without stalling its producers.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per serial bit (25 MHz / 115200, rounded).
- `FIFO_DEPTH`, 4, byte entries; power of two, ≥2.
- `clk_i`  in  1  system/pixel clock, 25 MHz.
- `rst_i`  in  1  reset; one clock, reset is synchronous and active-high.
- `data_i`  in  8  byte to transmit.
- `valid_i`  in  1  `data_i` is valid this cycle.
- `ready_o`  out  1  FIFO can accept a byte this cycle (not full).
- `tx_o`  out  1  serial line, idle high, registered.
- `busy_o`  out  1  frame in progress or FIFO non-empty.

## Operation
- Handshake: byte written on any rising edge with `valid_i && ready_o`; `valid_i` while `ready_o` low is ignored (byte dropped, no state change).
- `ready_o` = FIFO count < `FIFO_DEPTH`, computed from registered count; a pop in the same cycle does not raise it early.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_o`=1. If FIFO non-empty: pop head into 8-bit shift register, clear bit counter and baud counter, go START.
  - START: `tx_o`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: `tx_o`=shift[0]; every `CLKS_PER_BIT` cycles shift right, increment bit index 0..7; after bit 7, go STOP.
  - STOP: `tx_o`=1 for `CLKS_PER_BIT` cycles. On its last cycle, if FIFO non-empty, pop and go directly to START (no idle gap); else go IDLE.
- Baud counter: width clog2(`CLKS_PER_BIT`), counts 0..`CLKS_PER_BIT`-1, wraps to 0 on bit boundary.
- FIFO: circular, pointers wrap modulo `FIFO_DEPTH`; count width clog2(`FIFO_DEPTH`)+1. Simultaneous push and pop: count unchanged, both pointers advance; legal when full (pop frees slot, push still blocked by registered `ready_o`) and when holding one entry.
- Pop only from FSM in IDLE or last STOP cycle; never pops when empty.
- `busy_o` = (state ≠ IDLE) || (count ≠ 0).

## Timing
- Reset values: `tx_o`=1, `ready_o`=1, `busy_o`=0, state IDLE, count 0, pointers 0.
- Reset mid-frame: on the reset edge frame aborts, `tx_o`=1 from that edge, FIFO contents discarded.
- Latency: byte accepted at edge k into empty FIFO with FSM idle → popped at edge k+1, `tx_o` low from edge k+1.
- Frame = 10 × `CLKS_PER_BIT` = 2170 cycles = 86.8 µs; each bit exactly 217 cycles (8.68 µs).
- Back-to-back bytes: start bit of byte n+1 begins the cycle after the last stop-bit cycle of byte n.
- `busy_o` falls the cycle after the last stop-bit cycle when FIFO empty.

## Structure
- Shared package `vga_pkg`: `CLKS_PER_BIT` default (217), UART frame constants (data bits 8, stop bits 1), FSM state enum `tx_state_t`.
- One sub-module: `sync_fifo` (parameterised width/depth, push/pop/full/empty/count), reusable by the receive path.
- `uart_tx_fifo` holds FSM, baud counter, shift register, output register.

## Test plan
- Reset: hold `rst_i` 3 cycles → `tx_o`=1, `ready_o`=1, `busy_o`=0; no transitions on `tx_o` for 5000 cycles.
- Single byte 0x41: push once → `tx_o` low 1 cycle after accept, bits 1,0,0,0,0,0,1,0 then stop, each 217 cycles; `busy_o` low at cycle 2171 after accept.
- Burst of 6 bytes 0x4F,0x1D,0x43,0x00,0xFF,0x55 with `valid_i` held → first 5 accepted (one popped immediately, 4 buffered), `ready_o` low, 6th held until a slot frees; all 6 frames back-to-back, no idle gap, decoded sequence matches.
- Push while full with `valid_i` pulsed one cycle → byte dropped; transmitted stream omits it.
- Reset mid-DATA of 0xA5 with 2 queued → `tx_o`=1 next cycle, `busy_o`=0, no further frames.
- Loopback: connect `tx_o` to the existing UART receiver, send 0x00..0xFF → receiver reproduces all 256 bytes in order.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the host serial link and text-mode VGA controller.
// Holds the UART frame constants and the transmitter state encoding.
package vga_pkg;
    localparam int CLKS_PER_BIT_DEF = 217;
    localparam int UART_DATA_BITS   = 8;
    localparam int UART_STOP_BITS   = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular synchronous FIFO with registered occupancy count.
// The head entry is presented combinationally so a pop consumes it on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a small FIFO over valid/ready
// and are serialised LSB-first on a registered, idle-high tx line.
module uart_tx_fifo
    import vga_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud;
    logic [BIT_W-1:0]  bit_idx;
    logic [7:0]        shift;
    logic [7:0]        head;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              bit_end;

    assign bit_end = (baud == BAUD_LAST);
    assign ready_o = !full;
    assign push    = valid_i && ready_o;
    // Popping on the last stop cycle lets the next start bit follow with no idle gap.
    assign pop     = !empty && ((state == TX_IDLE) || (state == TX_STOP && bit_end));
    assign busy_o  = (state != TX_IDLE) || (count != '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (data_i),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // tx_o is loaded with the level of the bit being entered, keeping it a true register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            tx_o    <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (pop) begin
                        state   <= TX_START;
                        baud    <= '0;
                        bit_idx <= '0;
                        tx_o    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        state <= TX_DATA;
                        baud  <= '0;
                        tx_o  <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) begin
                            state <= TX_STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            tx_o <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        if (pop) begin
                            state <= TX_START;
                            tx_o  <= 1'b0;
                        end else begin
                            state <= TX_IDLE;
                            tx_o  <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop) begin
            shift <= head;
        end else if (state == TX_DATA && bit_end) begin
            shift <= {1'b0, shift[7:1]};
        end
    end
endmodule
